// File: rtl/spi_cfg_pkg.sv
// ============================================================================
// Module  : spi_cfg_pkg
// Brief   : Shared addresses, frame layout and FSM state type for the SPI TX
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cfg_pkg;

  localparam logic [6:0] ADDR_COS1_0 = 7'h01;
  localparam logic [6:0] ADDR_COS1_1 = 7'h02;
  localparam logic [6:0] ADDR_SIN1_0 = 7'h03;
  localparam logic [6:0] ADDR_SIN1_1 = 7'h04;
  localparam logic [6:0] ADDR_COS2_0 = 7'h05;
  localparam logic [6:0] ADDR_COS2_1 = 7'h06;
  localparam logic [6:0] ADDR_SIN2_0 = 7'h07;
  localparam logic [6:0] ADDR_SIN2_1 = 7'h08;

  localparam int FRAME_W       = 32;
  localparam int COEF_W        = 5;
  localparam int NUM_COEF      = 4;
  localparam int FRM_WRITE_BIT = 31;
  localparam int FRM_ADDR_MSB  = 30;
  localparam int FRM_ADDR_LSB  = 24;
  localparam int FRM_COEF0_MSB = 23;
  localparam int FRM_PAD_MSB   = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_SHIFT = ST_SHIFT,
    S_HOLD  = ST_HOLD,
    S_GAP   = ST_GAP
  } spi_state_e;

  // Coefficient i sits COEF_W*i bits below coefficient 0; the low nibble is pad.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic                              wr,
    input logic [6:0]                        addr,
    input logic [NUM_COEF-1:0][COEF_W-1:0]   coef
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRM_WRITE_BIT] = wr;
    f[FRM_ADDR_MSB:FRM_ADDR_LSB] = addr;
    for (int i = 0; i < NUM_COEF; i++) begin
      f[FRM_COEF0_MSB - COEF_W*i -: COEF_W] = coef[i];
    end
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
// Module  : spi_clk_div
// Brief   : One-cycle tick every CLK_DIV cycles while enabled; restarts on enable
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] C_TERM = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == C_TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == C_TERM);

endmodule

`default_nettype wire

// File: rtl/spi_master_tx.sv
// ============================================================================
// Module  : spi_master_tx
// Brief   : Mode-0 SPI master sending one 32-bit command frame per request
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_tx
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [6:0]                      cmd_addr,
  input  logic [NUM_COEF-1:0][COEF_W-1:0] cmd_data,
  output logic                            rsp_valid,
  output logic [FRAME_W-1:0]              rsp_data,
  output logic                            SCLK,
  output logic                            MOSI,
  input  logic                            MISO,
  output logic                            ss,
  output logic                            busy
);

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic               sclk_q, sclk_d;
  logic               ss_q, ss_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [FRAME_W-1:0] rsp_data_q, rsp_data_d;

  logic tick;
  logic div_en;
  logic sclk_rise;
  logic sclk_fall;

  assign div_en    = (state_q != S_IDLE);
  assign sclk_rise = (state_q == S_SHIFT) && tick && !sclk_q;
  assign sclk_fall = (state_q == S_SHIFT) && tick &&  sclk_q;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock  (clock),
    .reset  (reset),
    .enable (div_en),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (cmd_valid) begin
          state_d = S_SETUP;
          tx_d    = build_frame(cmd_write, cmd_addr, cmd_data);
          rx_d    = '0;
          ss_d    = 1'b0;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (sclk_rise) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[FRAME_W-2:0], MISO};
          if (bit_cnt_q != 6'd32) bit_cnt_d = bit_cnt_q + 6'd1;
        end
        // Shifting in a zero leaves MOSI low once the last bit has gone out.
        if (sclk_fall) begin
          sclk_d = 1'b0;
          tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
          if (bit_cnt_q == 6'd32) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d     = S_GAP;
          ss_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign SCLK      = sclk_q;
  assign MOSI      = tx_q[FRAME_W-1];
  assign ss        = ss_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_tx.sv
// ============================================================================
// Module  : tb_spi_master_tx
// Brief   : Directed self-checking bench for spi_master_tx (CLK_DIV 4 and 2)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b0;
  logic              cmd_write;
  logic [6:0]        cmd_addr;
  logic [3:0][4:0]   cmd_data;

  logic        cv0, cr0, rv0, sclk0, mosi0, miso0, ss0, busy0;
  logic [31:0] rd0;
  logic        cv1, cr1, rv1, sclk1, mosi1, miso1, ss1, busy1;
  logic [31:0] rd1;

  assign miso1 = 1'b0;

  spi_master_tx #(.CLK_DIV(4)) u0 (
    .clock(clk), .reset(reset), .cmd_valid(cv0), .cmd_ready(cr0),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rv0), .rsp_data(rd0), .SCLK(sclk0), .MOSI(mosi0),
    .MISO(miso0), .ss(ss0), .busy(busy0)
  );

  spi_master_tx #(.CLK_DIV(2)) u1 (
    .clock(clk), .reset(reset), .cmd_valid(cv1), .cmd_ready(cr1),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rv1), .rsp_data(rd1), .SCLK(sclk1), .MOSI(mosi1),
    .MISO(miso1), .ss(ss1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Bus monitor and MISO slave model, evaluated on the falling clock edge.
  int          cyc = 0;
  logic [31:0] pat0 = 32'h0;
  logic [31:0] cap0 = 32'h0, cap1 = 32'h0;
  int          fr0 = 0, rises0 = 0, falls0 = 0, rsp_cnt0 = 0, sclk_bad0 = 0;
  int          ss_run0 = 0, last_gap0 = 0, acc0 = 0, prev_acc0 = 0;
  int          rises1 = 0, rise_c1 = 0, prev_rise_c1 = 0;
  logic        sclk_p0 = 1'b0, busy_p0 = 1'b0, sclk_p1 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (busy0 && !busy_p0) begin
      prev_acc0 = acc0;
      acc0      = cyc;
    end
    busy_p0 = busy0;
    if (ss0) begin
      fr0 = 0;
      ss_run0++;
    end else begin
      if (ss_run0 != 0) last_gap0 = ss_run0;
      ss_run0 = 0;
    end
    if (sclk0 && !sclk_p0 && !ss0) begin
      cap0 = {cap0[30:0], mosi0};
      fr0++;
      rises0++;
    end
    if (!sclk0 && sclk_p0) falls0++;
    if (sclk0 && ss0) sclk_bad0++;
    if (rv0) rsp_cnt0++;
    sclk_p0 = sclk0;
    miso0 = (fr0 < 32) ? pat0[31 - fr0] : 1'b0;

    if (sclk1 && !sclk_p1 && !ss1) begin
      cap1         = {cap1[30:0], mosi1};
      rises1++;
      prev_rise_c1 = rise_c1;
      rise_c1      = cyc;
    end
    sclk_p1 = sclk1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue0(input logic w, input logic [6:0] a, input logic [19:0] d);
    cmd_write = w; cmd_addr = a; cmd_data = d; cv0 = 1'b1;
    step();
    cv0 = 1'b0;
  endtask

  task automatic issue1(input logic w, input logic [6:0] a, input logic [19:0] d);
    cmd_write = w; cmd_addr = a; cmd_data = d; cv1 = 1'b1;
    step();
    cv1 = 1'b0;
  endtask

  task automatic wait_rsp(input bit unit1);
    int n = 0;
    while (!(unit1 ? rv1 : rv0) && n < 1000) begin step(); n++; end
  endtask

  task automatic wait_ready(input bit unit1);
    int n = 0;
    while (!(unit1 ? cr1 : cr0) && n < 1000) begin step(); n++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r, f, rc, a1, a2, n;
    cv0 = 1'b0; cv1 = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    #1 reset = 1'b1;
    step();
    chk("reset sclk", {31'h0, sclk0}, 32'h0);
    chk("reset ss", {31'h0, ss0}, 32'h1);
    chk("reset mosi", {31'h0, mosi0}, 32'h0);
    chk("reset busy", {31'h0, busy0}, 32'h0);
    chk("reset rsp_valid", {31'h0, rv0}, 32'h0);
    chk("reset rsp_data", rd0, 32'h0);
    reset = 1'b0;
    step();
    chk("post-reset cmd_ready", {31'h0, cr0}, 32'h1);

    // Write addr 0x03, coefficients {1,2,3,4}
    r = rises0; f = falls0; rc = rsp_cnt0;
    issue0(1'b1, 7'h03, {5'd4, 5'd3, 5'd2, 5'd1});
    t = cyc;
    chk("accept ss low", {31'h0, ss0}, 32'h0);
    chk("accept mosi bit31", {31'h0, mosi0}, 32'h1);
    chk("accept busy", {30'h0, busy0, cr0}, 32'h2);
    wait_rsp(0);
    chk("write rsp latency", cyc - t, 32'd264);
    wait_ready(0);
    chk("write ready latency", cyc - t, 32'd268);
    chk("write frame", cap0, 32'h8308_8640);
    chk("write rises", rises0 - r, 32'd32);
    chk("write falls", falls0 - f, 32'd32);
    chk("write rsp pulses", rsp_cnt0 - rc, 32'd1);

    // Read addr 0x08 with MISO pattern
    pat0 = 32'hDEAD_BEEF; rc = rsp_cnt0;
    issue0(1'b0, 7'h08, 20'h0);
    wait_rsp(0);
    chk("read rsp_data", rd0, 32'hDEAD_BEEF);
    step(); step(); step();
    chk("read rsp_data held", rd0, 32'hDEAD_BEEF);
    wait_ready(0);
    chk("read frame", cap0, 32'h0800_0000);
    chk("read rsp pulses", rsp_cnt0 - rc, 32'd1);

    // cmd_valid held high across two commands
    a1 = acc0;
    cmd_write = 1'b1; cmd_addr = 7'h04; cmd_data = 20'hA5A5A; cv0 = 1'b1;
    n = 0; while (acc0 == a1 && n < 1000) begin step(); n++; end
    a2 = acc0;
    n = 0; while (acc0 == a2 && n < 1000) begin step(); n++; end
    cv0 = 1'b0;
    chk("b2b accept spacing", acc0 - prev_acc0, 32'd269);
    chk("b2b ss gap", last_gap0, 32'd5);
    wait_ready(0);

    // Reset after the 10th SCLK rise
    pat0 = 32'h0; rc = rsp_cnt0;
    issue0(1'b0, 7'h01, 20'h12345);
    n = 0; while (fr0 != 10 && n < 1000) begin step(); n++; end
    chk("abort sclk before reset", {31'h0, sclk0}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort sclk", {31'h0, sclk0}, 32'h0);
    chk("abort ss", {31'h0, ss0}, 32'h1);
    chk("abort mosi", {31'h0, mosi0}, 32'h0);
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("abort no rsp", rsp_cnt0 - rc, 32'd0);
    chk("abort cmd_ready", {31'h0, cr0}, 32'h1);
    pat0 = 32'h1234_5678;
    issue0(1'b0, 7'h02, 20'h0);
    wait_rsp(0);
    chk("fresh rsp_data", rd0, 32'h1234_5678);
    wait_ready(0);
    chk("fresh frame", cap0, 32'h0200_0000);

    // CLK_DIV=2, inputs changed right after accept
    r = rises1;
    issue1(1'b1, 7'h05, {5'h0A, 5'h15, 5'h00, 5'h1F});
    t = cyc;
    cmd_write = 1'b0; cmd_addr = 7'h7F; cmd_data = 20'hFFFFF;
    wait_rsp(1);
    chk("div2 rsp latency", cyc - t, 32'd132);
    wait_ready(1);
    chk("div2 frame", cap1, 32'h85F8_2AA0);
    chk("div2 sclk period", rise_c1 - prev_rise_c1, 32'd4);
    chk("div2 rises", rises1 - r, 32'd32);

    // All eight coefficient addresses, decoded from MOSI
    for (int a = 1; a <= 8; a++) begin
      logic [19:0] d;
      d = {5'(31 - a), 5'(a + 16), 5'(a + 8), 5'(a)};
      issue0(1'b1, 7'(a), d);
      wait_ready(0);
      chk("loop addr", {24'h0, cap0[31:24]}, {24'h0, 1'b1, 7'(a)});
      chk("loop coef", {12'h0, cap0[8:4], cap0[13:9], cap0[18:14], cap0[23:19]}, {12'h0, d});
      chk("loop pad", {28'h0, cap0[3:0]}, 32'h0);
    end

    chk("sclk idle while ss high", sclk_bad0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
